// File: rtl/juego_reflejos_multi.sv
// N-player LED reflex game: debounced buttons, pseudo-random red wait, green
// reaction window, foul penalties, round counting and winner/score display.
module juego_reflejos_multi #(
  parameter int N_JUG      = 2,
  parameter int RONDAS     = 9,
  parameter int DEB_CIC    = 4,
  parameter int ESPERA_MIN = 16,
  parameter int ESPERA_MSK = 15,
  parameter int VENTANA    = 32
) (
  input  logic                       clock,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [N_JUG-1:0]           Boton,
  input  logic [$clog2(N_JUG)-1:0]   Sel,
  output logic                       LedRojo,
  output logic                       LedVerde,
  output logic                       LedFin,
  output logic [N_JUG-1:0]           Ganador,
  output logic [N_JUG-1:0]           Punto,
  output logic [6:0]                 displaytotal
);

  localparam int SCW = $clog2(RONDAS + 1);
  localparam int DCW = $clog2(DEB_CIC + 1);
  localparam int SW  = $clog2(N_JUG);
  localparam int TW  = 16;

  typedef enum logic [2:0] {IDLE, ESPERA, ACTIVO, FALTA, CIERRE, FIN} state_t;

  logic [N_JUG-1:0]           sync1_q, sync2_q, acc_q, accPrev_q;
  logic [N_JUG-1:0][DCW-1:0]  deb_q;
  logic [N_JUG-1:0]           press;
  logic [7:0]                 lfsr_q;
  logic [TW-1:0]              waitLoad;

  state_t                     state_q, state_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [SCW-1:0]             round_q, round_d;
  logic [N_JUG-1:0][SCW-1:0]  score_q, score_d;
  logic [N_JUG-1:0]           punto_q, punto_d;
  logic                       startPrev_q;
  logic                       won;

  logic [SCW-1:0]             maxScore;
  logic [N_JUG-1:0]           winMask;
  logic [SCW-1:0]             dispVal;
  logic                       blank;

  // Synchroniser plus per-button debounce; a level is accepted only after
  // it has differed from the accepted value for DEB_CIC consecutive cycles.
  always_ff @(posedge clock) begin
    if (Reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      acc_q     <= '0;
      accPrev_q <= '0;
      deb_q     <= '0;
    end else begin
      sync1_q   <= Boton;
      sync2_q   <= sync1_q;
      accPrev_q <= acc_q;
      for (int i = 0; i < N_JUG; i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          deb_q[i] <= '0;
        end else if (deb_q[i] == DCW'(DEB_CIC - 1)) begin
          acc_q[i] <= sync2_q[i];
          deb_q[i] <= '0;
        end else begin
          deb_q[i] <= deb_q[i] + DCW'(1);
        end
      end
    end
  end

  assign press = acc_q & ~accPrev_q;

  always_ff @(posedge clock) begin
    if (Reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign waitLoad = TW'(ESPERA_MIN) + TW'(lfsr_q & 8'(ESPERA_MSK));

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      round_q     <= '0;
      score_q     <= '0;
      punto_q     <= '0;
      startPrev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      round_q     <= round_d;
      score_q     <= score_d;
      punto_q     <= punto_d;
      startPrev_q <= Start;
    end
  end

  // Dropping Start aborts any running phase; a press beats an expiring timer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    round_d = round_q;
    score_d = score_q;
    punto_d = '0;
    won     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start && !startPrev_q) begin
          state_d = ESPERA;
          score_d = '0;
          round_d = '0;
          timer_d = waitLoad;
        end
      end
      ESPERA: begin
        if (!Start) begin
          state_d = IDLE;
        end else if (|press) begin
          state_d = FALTA;
          for (int i = 0; i < N_JUG; i++) begin
            if (press[i] && score_q[i] != '0) score_d[i] = score_q[i] - SCW'(1);
          end
        end else if (timer_q == '0) begin
          state_d = ACTIVO;
          timer_d = TW'(VENTANA - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ACTIVO: begin
        if (!Start) begin
          state_d = IDLE;
        end else if (|press) begin
          state_d = CIERRE;
          for (int i = 0; i < N_JUG; i++) begin
            if (press[i] && !won) begin
              won        = 1'b1;
              score_d[i] = score_q[i] + SCW'(1);
              punto_d[i] = 1'b1;
            end
          end
        end else if (timer_q == '0) begin
          state_d = CIERRE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      FALTA: begin
        if (!Start) begin
          state_d = IDLE;
        end else begin
          state_d = ESPERA;
          timer_d = waitLoad;
        end
      end
      CIERRE: begin
        if (!Start) begin
          state_d = IDLE;
        end else begin
          round_d = round_q + SCW'(1);
          if (round_d == SCW'(RONDAS)) begin
            state_d = FIN;
          end else begin
            state_d = ESPERA;
            timer_d = waitLoad;
          end
        end
      end
      FIN: begin
        if (!Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    maxScore = '0;
    winMask  = '0;
    for (int i = 0; i < N_JUG; i++) begin
      if (score_q[i] > maxScore) maxScore = score_q[i];
    end
    for (int i = 0; i < N_JUG; i++) begin
      winMask[i] = (score_q[i] == maxScore);
    end
  end

  assign LedRojo  = (state_q == ESPERA) || (state_q == FALTA);
  assign LedVerde = (state_q == ACTIVO);
  assign LedFin   = (state_q == FIN);
  assign Ganador  = (state_q == FIN) ? winMask : '0;
  assign Punto    = punto_q;

  // Game over shows the best score; otherwise the selected player's score.
  always_comb begin
    dispVal = '0;
    blank   = 1'b1;
    if (state_q == FIN) begin
      dispVal = maxScore;
      blank   = 1'b0;
    end else begin
      for (int i = 0; i < N_JUG; i++) begin
        if (Sel == SW'(i)) begin
          dispVal = score_q[i];
          blank   = 1'b0;
        end
      end
    end
    case (4'(dispVal))
      4'd0:    displaytotal = 7'b0111111;
      4'd1:    displaytotal = 7'b0000110;
      4'd2:    displaytotal = 7'b1011011;
      4'd3:    displaytotal = 7'b1001111;
      4'd4:    displaytotal = 7'b1100110;
      4'd5:    displaytotal = 7'b1101101;
      4'd6:    displaytotal = 7'b1111101;
      4'd7:    displaytotal = 7'b0000111;
      4'd8:    displaytotal = 7'b1111111;
      4'd9:    displaytotal = 7'b1101111;
      default: displaytotal = 7'b0000000;
    endcase
    if (blank) displaytotal = 7'b0000000;
  end

endmodule

// File: tb/tb_juego_reflejos_multi.sv
// Directed bench for the reflex game: two players, three rounds, fixed wait.
module tb_juego_reflejos_multi;

  logic       clock;
  logic       Reset;
  logic       Start;
  logic [1:0] Boton;
  logic [0:0] Sel;
  logic       LedRojo, LedVerde, LedFin;
  logic [1:0] Ganador, Punto;
  logic [6:0] displaytotal;

  int vectorsApplied = 0;
  int miscompares    = 0;
  int p0Count = 0, p1Count = 0, widePulses = 0;
  logic [1:0] prevPunto = 2'b00;
  int base0, base1;

  localparam logic [6:0] SEG0 = 7'b0111111;
  localparam logic [6:0] SEG1 = 7'b0000110;

  juego_reflejos_multi #(
    .N_JUG(2), .RONDAS(3), .DEB_CIC(2), .ESPERA_MIN(4), .ESPERA_MSK(0), .VENTANA(8)
  ) dut (
    .clock(clock), .Reset(Reset), .Start(Start), .Boton(Boton), .Sel(Sel),
    .LedRojo(LedRojo), .LedVerde(LedVerde), .LedFin(LedFin),
    .Ganador(Ganador), .Punto(Punto), .displaytotal(displaytotal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Tallies scoring pulses per player and flags any pulse wider than a cycle.
  always @(negedge clock) begin
    if (Punto[0]) p0Count++;
    if (Punto[1]) p1Count++;
    if (Punto != 2'b00 && prevPunto != 2'b00) widePulses++;
    prevPunto = Punto;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorsApplied++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // which: 0 = LedRojo, 1 = LedVerde, 2 = LedFin
  task automatic waitLed(input int which, input logic level, input int maxCyc, input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < maxCyc && !seen; n++) begin
      @(negedge clock);
      case (which)
        0:       seen = (LedRojo == level);
        1:       seen = (LedVerde == level);
        default: seen = (LedFin == level);
      endcase
    end
    checkOutput(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [1:0] mask, input int cycles);
    Boton = mask;
    repeat (cycles) tick();
    Boton = 2'b00;
  endtask

  task automatic playRound(input logic [1:0] mask);
    waitLed(1, 1'b1, 40, "verde_up");
    tick();
    applyStimulus(mask, 4);
    waitLed(1, 1'b0, 40, "verde_down");
  endtask

  // Starts right after ESPERA is entered so the press lands inside the wait.
  task automatic doFoul(input logic [1:0] mask);
    applyStimulus(mask, 4);
    tick();
    checkOutput("foul_rojo", {31'b0, LedRojo}, 32'd1);
    checkOutput("foul_verde", {31'b0, LedVerde}, 32'd0);
    tick();
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Boton = 2'b00; Sel = 1'b0;
    repeat (3) tick();
    checkOutput("rst_rojo", {31'b0, LedRojo}, 32'd0);
    checkOutput("rst_verde", {31'b0, LedVerde}, 32'd0);
    checkOutput("rst_fin", {31'b0, LedFin}, 32'd0);
    checkOutput("rst_ganador", {30'b0, Ganador}, 32'd0);
    checkOutput("rst_punto", {30'b0, Punto}, 32'd0);
    checkOutput("rst_display", {25'b0, displaytotal}, {25'b0, SEG0});
    Reset = 1'b0;
    repeat (2) tick();

    // Round 1: player 0 wins
    Start = 1'b1;
    base0 = p0Count; base1 = p1Count;
    playRound(2'b01);
    repeat (3) tick();
    checkOutput("r1_punto0", p0Count - base0, 32'd1);
    checkOutput("r1_punto1", p1Count - base1, 32'd0);
    checkOutput("r1_display", {25'b0, displaytotal}, {25'b0, SEG1});

    // Round 2: glitch shorter than debounce, window times out
    Sel = 1'b1;
    base0 = p0Count; base1 = p1Count;
    waitLed(1, 1'b1, 40, "r2_verde_up");
    tick();
    applyStimulus(2'b10, 1);
    waitLed(1, 1'b0, 40, "r2_verde_down");
    checkOutput("r2_cierre_rojo", {31'b0, LedRojo}, 32'd0);
    checkOutput("r2_punto0", p0Count - base0, 32'd0);
    checkOutput("r2_punto1", p1Count - base1, 32'd0);
    #1 checkOutput("r2_display1", {25'b0, displaytotal}, {25'b0, SEG0});

    // Round 3 wait: fouls, with saturation at zero
    waitLed(0, 1'b1, 10, "r3_rojo_up");
    doFoul(2'b01);
    Sel = 1'b0;
    #1 checkOutput("foul1_score0", {25'b0, displaytotal}, {25'b0, SEG0});
    doFoul(2'b10);
    Sel = 1'b1;
    #1 checkOutput("foul2_score1", {25'b0, displaytotal}, {25'b0, SEG0});
    doFoul(2'b01);
    Sel = 1'b0;
    #1 checkOutput("foul3_score0", {25'b0, displaytotal}, {25'b0, SEG0});

    // Round 3: simultaneous presses, lowest index wins, game ends
    Sel = 1'b1;
    base0 = p0Count; base1 = p1Count;
    waitLed(1, 1'b1, 40, "r3_verde_up");
    tick();
    applyStimulus(2'b11, 4);
    waitLed(2, 1'b1, 10, "fin_up");
    checkOutput("tie_punto0", p0Count - base0, 32'd1);
    checkOutput("tie_punto1", p1Count - base1, 32'd0);
    checkOutput("fin_ganador", {30'b0, Ganador}, 32'd1);
    checkOutput("fin_display", {25'b0, displaytotal}, {25'b0, SEG1});
    checkOutput("fin_rojo", {31'b0, LedRojo}, 32'd0);
    base1 = p1Count;
    applyStimulus(2'b10, 4);
    repeat (4) tick();
    checkOutput("fin_ignore_punto", p1Count - base1, 32'd0);
    checkOutput("fin_ignore_ganador", {30'b0, Ganador}, 32'd1);

    // Back to IDLE with scores held, then a restart clears them
    Start = 1'b0;
    tick();
    checkOutput("idle_fin", {31'b0, LedFin}, 32'd0);
    checkOutput("idle_ganador", {30'b0, Ganador}, 32'd0);
    checkOutput("idle_rojo", {31'b0, LedRojo}, 32'd0);
    Sel = 1'b0;
    #1 checkOutput("idle_held0", {25'b0, displaytotal}, {25'b0, SEG1});
    tick();
    Start = 1'b1;
    tick();
    checkOutput("restart_clear", {25'b0, displaytotal}, {25'b0, SEG0});
    checkOutput("restart_rojo", {31'b0, LedRojo}, 32'd1);

    // Game 2: 1/1 tie -> both winners
    base0 = p0Count; base1 = p1Count;
    playRound(2'b01);
    playRound(2'b10);
    playRound(2'b00);
    waitLed(2, 1'b1, 10, "g2_fin_up");
    checkOutput("g2_punto0", p0Count - base0, 32'd1);
    checkOutput("g2_punto1", p1Count - base1, 32'd1);
    checkOutput("g2_ganador", {30'b0, Ganador}, 32'd3);
    checkOutput("g2_display", {25'b0, displaytotal}, {25'b0, SEG1});

    // Game 3: reset during the reaction window
    Start = 1'b0;
    repeat (2) tick();
    Start = 1'b1;
    tick();
    playRound(2'b01);
    Sel = 1'b0;
    #1 checkOutput("g3_score0", {25'b0, displaytotal}, {25'b0, SEG1});
    waitLed(1, 1'b1, 40, "g3_verde_up");
    Reset = 1'b1;
    tick();
    checkOutput("rst2_verde", {31'b0, LedVerde}, 32'd0);
    checkOutput("rst2_rojo", {31'b0, LedRojo}, 32'd0);
    checkOutput("rst2_display", {25'b0, displaytotal}, {25'b0, SEG0});
    checkOutput("rst2_punto", {30'b0, Punto}, 32'd0);
    Reset = 1'b0;

    // Abort: Start dropping during the wait returns to IDLE
    waitLed(0, 1'b1, 10, "abort_rojo_up");
    Start = 1'b0;
    tick();
    checkOutput("abort_rojo", {31'b0, LedRojo}, 32'd0);
    checkOutput("abort_verde", {31'b0, LedVerde}, 32'd0);
    checkOutput("punto_width", widePulses, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
